// File: rtl/poly_nco.sv
// poly_nco: time-multiplexed polyphonic oscillator bank, one shared waveform datapath swept one voice per clock.
// Latency: sample_tick to out_valid is VOICES+1 cycles; out holds between pulses.
// Backpressure: none; a tick arriving mid-sweep or with out_valid high is dropped and sets sticky overrun.
// Optional: define POLY_NCO_SATURATE_EN for an unattenuated, saturating mix plus a sticky clip output.
module poly_nco #(
  parameter int VOICES     = 4,
  parameter int PHASE_BITS = 24,
  parameter int OUT_BITS   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sample_tick,
  input  logic                      wr_en,
  input  logic [$clog2(VOICES)-1:0] wr_voice,
  input  logic [PHASE_BITS-1:0]     wr_inc,
  input  logic [1:0]                wr_mode,
  input  logic                      wr_sync,
  output logic [OUT_BITS-1:0]       out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
`ifdef POLY_NCO_SATURATE_EN
  ,
  output logic                      clip
`endif
);

  localparam int VW = $clog2(VOICES);
  localparam int AW = OUT_BITS + VW;
  localparam logic [VW-1:0] LAST_VOICE = VW'(VOICES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  // staging entries, written at any time by control logic
  logic [PHASE_BITS-1:0] stg_inc_q  [VOICES];
  logic [1:0]            stg_mode_q [VOICES];
  logic                  stg_sync_q [VOICES];

  // active voice registers, loaded only at commit
  logic [PHASE_BITS-1:0] act_inc_q  [VOICES];
  logic [1:0]            act_mode_q [VOICES];
  logic [PHASE_BITS-1:0] phase_q    [VOICES];

  logic [VW-1:0]         cnt_q;
  logic signed [AW-1:0]  acc_q;
  logic [OUT_BITS-1:0]   out_q;
  logic                  out_valid_q;
  logic                  overrun_q;

  logic                  start;
  logic                  last;
  logic [OUT_BITS-1:0]   p_val;
  logic [OUT_BITS-1:0]   q_val;
  logic [OUT_BITS-1:0]   tri_val;
  logic                  ph_msb;
  logic [OUT_BITS-1:0]   wave;
  logic signed [AW-1:0]  acc_sum;
  logic [OUT_BITS-1:0]   mix_d;

`ifdef POLY_NCO_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(VW+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(VW+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
  logic sat_hit;
  logic clip_q;
`endif

  // sweep state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // sweep next-state: an accepted tick starts a sweep, the last voice ends it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // sweep outputs: a tick in the out_valid cycle is treated as a collision, not a start
  always_comb begin
    busy  = (state_q == RUN);
    start = (state_q == IDLE) && sample_tick && !out_valid_q;
    last  = (state_q == RUN) && (cnt_q == LAST_VOICE);
  end

  // waveform of the voice selected by cnt_q, from its pre-update phase, and the mix result
  always_comb begin
    ph_msb  = phase_q[cnt_q][PHASE_BITS-1];
    p_val   = phase_q[cnt_q][PHASE_BITS-1 -: OUT_BITS];
    q_val   = phase_q[cnt_q][PHASE_BITS-2 -: OUT_BITS];
    tri_val = ph_msb ? ~q_val : q_val;
    case (act_mode_q[cnt_q])
      2'd1:    wave = {~p_val[OUT_BITS-1], p_val[OUT_BITS-2:0]};
      2'd2:    wave = ph_msb ? {1'b1, {(OUT_BITS-1){1'b0}}} : {1'b0, {(OUT_BITS-1){1'b1}}};
      2'd3:    wave = {~tri_val[OUT_BITS-1], tri_val[OUT_BITS-2:0]};
      default: wave = '0;
    endcase
    acc_sum = acc_q + $signed({{VW{wave[OUT_BITS-1]}}, wave});
`ifdef POLY_NCO_SATURATE_EN
    sat_hit = 1'b0;
    if (acc_sum > SAT_MAX) begin
      mix_d   = {1'b0, {(OUT_BITS-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (acc_sum < SAT_MIN) begin
      mix_d   = {1'b1, {(OUT_BITS-1){1'b0}}};
      sat_hit = 1'b1;
    end else begin
      mix_d   = OUT_BITS'(acc_sum);
    end
`else
    mix_d = OUT_BITS'(acc_sum >>> VW);
`endif
  end

  // staging writes land after the commit, so a write in the tick cycle waits for the next tick
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        stg_inc_q[i]  <= '0;
        stg_mode_q[i] <= '0;
        stg_sync_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (wr_en && (wr_voice == VW'(i))) begin
          stg_inc_q[i]  <= wr_inc;
          stg_mode_q[i] <= wr_mode;
          stg_sync_q[i] <= wr_sync;
        end else if (start) begin
          stg_sync_q[i] <= 1'b0;
        end
      end
    end
  end

  // commit staging into the active set; otherwise advance the phase of the voice being swept
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        act_inc_q[i]  <= '0;
        act_mode_q[i] <= '0;
        phase_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (start) begin
          act_inc_q[i]  <= stg_inc_q[i];
          act_mode_q[i] <= stg_mode_q[i];
          if (stg_sync_q[i]) phase_q[i] <= '0;
        end else if (busy && (cnt_q == VW'(i))) begin
          phase_q[i] <= phase_q[i] + act_inc_q[i];
        end
      end
    end
  end

  // voice counter, mix accumulator, result register and sticky flags
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef POLY_NCO_SATURATE_EN
      clip_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= last;
      if (sample_tick && !start) overrun_q <= 1'b1;
      if (start) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + VW'(1);
        acc_q <= acc_sum;
      end
      if (last) out_q <= mix_d;
`ifdef POLY_NCO_SATURATE_EN
      if (last && sat_hit) clip_q <= 1'b1;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
`ifdef POLY_NCO_SATURATE_EN
  assign clip      = clip_q;
`endif

endmodule

// File: tb/tb_poly_nco.sv
// tb_poly_nco: randomized and directed stimulus against an arithmetic reference model, scoreboard on out_valid.
module tb_poly_nco;
  localparam int VOICES = 4;
  localparam int PB     = 24;
  localparam int OB     = 16;
  localparam int VW     = 2;
  localparam int unsigned HALF  = 32'd1 << (PB - 1);
  localparam int unsigned PMASK = (32'd1 << PB) - 32'd1;

  logic          clock = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic          wr_en;
  logic [VW-1:0] wr_voice;
  logic [PB-1:0] wr_inc;
  logic [1:0]    wr_mode;
  logic          wr_sync;
  logic [OB-1:0] out;
  logic          out_valid;
  logic          busy;
  logic          overrun;
`ifdef POLY_NCO_SATURATE_EN
  logic          clip;
`endif

  poly_nco #(.VOICES(VOICES), .PHASE_BITS(PB), .OUT_BITS(OB)) dut (
    .clock(clock), .reset(reset), .sample_tick(sample_tick),
    .wr_en(wr_en), .wr_voice(wr_voice), .wr_inc(wr_inc), .wr_mode(wr_mode), .wr_sync(wr_sync),
    .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
`ifdef POLY_NCO_SATURATE_EN
    , .clip(clip)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // reference model state
  int unsigned s_inc [VOICES];
  int unsigned a_inc [VOICES];
  int unsigned ph    [VOICES];
  int          s_mode[VOICES];
  int          a_mode[VOICES];
  bit          s_sync[VOICES];
  int          sweep_pos = 0;   // 0 idle, 1..VOICES busy, VOICES+1 result cycle
  bit          exp_overrun = 1'b0;
  bit          exp_clip = 1'b0;
  logic [OB-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wave(input int unsigned phase, input int mode);
    int unsigned q, t;
    case (mode)
      1: return int'(phase >> (PB - OB)) - 32768;
      2: return (phase < HALF) ? 32767 : -32768;
      3: begin
        q = (phase % HALF) >> (PB - 1 - OB);
        t = (phase < HALF) ? q : (32'd65535 - q);
        return int'(t) - 32768;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_sweep();
    int sum = 0;
    int res;
    for (int v = 0; v < VOICES; v++) begin
      a_inc[v]  = s_inc[v];
      a_mode[v] = s_mode[v];
      if (s_sync[v]) ph[v] = 0;
      s_sync[v] = 1'b0;
    end
    for (int v = 0; v < VOICES; v++) begin
      sum += wave(ph[v], a_mode[v]);
      ph[v] = (ph[v] + a_inc[v]) & PMASK;
    end
`ifdef POLY_NCO_SATURATE_EN
    if (sum > 32767)       begin res = 32767;  exp_clip = 1'b1; end
    else if (sum < -32768) begin res = -32768; exp_clip = 1'b1; end
    else                   res = sum;
`else
    res = (sum >= 0) ? (sum / VOICES) : -((-sum + VOICES - 1) / VOICES);
`endif
    exp_q.push_back(OB'(res));
  endtask

  task automatic model_edge(input bit rst, input bit tk, input bit we, input int v,
                            input int unsigned inc, input int md, input bit sy);
    bit accept;
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        s_inc[i] = 0; a_inc[i] = 0; ph[i] = 0; s_mode[i] = 0; a_mode[i] = 0; s_sync[i] = 1'b0;
      end
      exp_q.delete();
      sweep_pos   = 0;
      exp_overrun = 1'b0;
      exp_clip    = 1'b0;
      return;
    end
    accept = tk && (sweep_pos == 0);
    if (sweep_pos > 0) begin
      sweep_pos++;
      if (sweep_pos > VOICES + 1) sweep_pos = 0;
    end
    if (accept) begin
      model_sweep();
      sweep_pos = 1;
    end else if (tk) begin
      exp_overrun = 1'b1;
    end
    if (we) begin
      s_inc[v]  = inc & PMASK;
      s_mode[v] = md;
      s_sync[v] = sy;
    end
  endtask

  task automatic cyc(input bit rst, input bit tk, input bit we, input int v,
                     input int unsigned inc, input int md, input bit sy);
    reset       = rst;
    sample_tick = tk;
    wr_en       = we;
    wr_voice    = VW'(v);
    wr_inc      = PB'(inc);
    wr_mode     = 2'(md);
    wr_sync     = sy;
    @(posedge clock);
    model_edge(rst, tk, we, v, inc, md, sy);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic write(input int v, input int unsigned inc, input int md, input bit sy);
    cyc(1'b0, 1'b0, 1'b1, v, inc, md, sy);
  endtask

  task automatic tick();
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
  endtask

  // monitor: per-cycle control checks, and scoreboard pop whenever a result is presented
  initial begin
    logic [OB-1:0] e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        check("busy", 32'(busy), 32'((sweep_pos >= 1) && (sweep_pos <= VOICES)));
        check("out_valid", 32'(out_valid), 32'(sweep_pos == VOICES + 1));
        check("overrun", 32'(overrun), 32'(exp_overrun));
`ifdef POLY_NCO_SATURATE_EN
        check("clip", 32'(clip), 32'(exp_clip));
`endif
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got out_valid=1 with out=0x%0h expected no result at %0t", out, $time);
          end else begin
            e = exp_q.pop_front();
            check("out", 32'(out), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    int unsigned r_inc;
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    mon_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    @(negedge clock);
    check("reset_out", 32'(out), 32'd0);
    idle(2);

    // saw on voice 0, two successive samples
    write(0, 32'h100000, 1, 1'b0);
    tick(); idle(6);
    tick(); idle(6);

    // all voices square at phase 0
    for (int v = 0; v < VOICES; v++) write(v, 0, 2, 1'b1);
    tick(); idle(6);

    // voice 1 saw at half-rate: phase wraps every second sample
    for (int v = 0; v < VOICES; v++) write(v, 0, 0, 1'b1);
    write(1, 32'h800000, 1, 1'b1);
    for (int k = 0; k < 3; k++) begin tick(); idle(6); end

    // tick collision two cycles into a sweep
    tick(); idle(1); tick(); idle(6);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // tick collision in the out_valid cycle
    tick(); idle(4); tick(); idle(3);

    // staging writes while busy and in the tick cycle
    write(2, 32'h040000, 3, 1'b1);
    tick(); idle(2);
    write(2, 32'h123456, 1, 1'b1);
    idle(4);
    cyc(1'b0, 1'b1, 1'b1, 2, 32'h200000, 2, 1'b1);
    idle(6);
    tick(); idle(6);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r_inc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 32'h3FFFF) : ($urandom & PMASK);
      cyc(1'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, VOICES - 1),
          r_inc, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end
    idle(8);

    // reset two cycles into a sweep aborts it
    write(3, 32'h0ABCDE, 2, 1'b0);
    tick(); idle(1);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    @(negedge clock);
    check("abort_out", 32'(out), 32'd0);
    idle(8);

    // recovery after reset
    write(3, 32'h0ABCDE, 3, 1'b0);
    write(0, 32'h001000, 1, 1'b0);
    tick(); idle(6);
    tick(); idle(6);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
